// File: rtl/ifu_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue_if
// Brief    : Instruction-memory, redirect and decoder handshakes of the fetch queue.
// Revision : 1.0
// ============================================================================
interface ifu_fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_req_addr_o;
  logic            imem_rsp_valid_i;
  logic [ILEN-1:0] imem_rsp_inst_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            inst_valid_o;
  logic            inst_ready_i;
  logic [ILEN-1:0] inst_o;
  logic [XLEN-1:0] pc_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_inst_i,
           redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, pc_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_inst_i,
           redirect_i, redirect_pc_i, inst_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_queue
// Brief    : PC owner issuing in-order imem fetches into a DEPTH-entry queue for the decoder.
// Revision : 1.0
// ============================================================================
module ifu_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  wire logic         clk_i,
  input  wire logic         rst_ni,
  ifu_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW+1:0] C_DEPTH = (CW+2)'(DEPTH);

  // Entry state is implicit: [head, fill) are FILLED, [fill, alloc) are PENDING.
  logic [XLEN-1:0] r_fetch_pc;
  logic [PW-1:0]   r_alloc_ptr;
  logic [PW-1:0]   r_fill_ptr;
  logic [PW-1:0]   r_head_ptr;
  logic [CW-1:0]   r_pend_cnt;
  logic [CW-1:0]   r_fill_cnt;
  logic [CW-1:0]   r_discard_cnt;
  logic [XLEN-1:0] r_pc_mem   [DEPTH];
  logic [ILEN-1:0] r_inst_mem [DEPTH];

  logic [CW+1:0] w_occupancy;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_fill;
  logic          w_drop;
  logic          w_inst_valid;
  logic          w_pop;

  assign w_occupancy  = (CW+2)'(r_pend_cnt) + (CW+2)'(r_fill_cnt) + (CW+2)'(r_discard_cnt);
  assign w_req_valid  = rst_ni && !bus.redirect_i && (w_occupancy < C_DEPTH);
  assign w_accept     = w_req_valid && bus.imem_req_ready_i;
  assign w_drop       = bus.imem_rsp_valid_i && (r_discard_cnt != '0);
  assign w_fill       = bus.imem_rsp_valid_i && (r_discard_cnt == '0) && !bus.redirect_i;
  assign w_inst_valid = (r_fill_cnt != '0);
  assign w_pop        = w_inst_valid && bus.inst_ready_i;

  assign bus.imem_req_valid_o = w_req_valid;
  assign bus.imem_req_addr_o  = r_fetch_pc;
  assign bus.inst_valid_o     = w_inst_valid;
  assign bus.inst_o           = w_inst_valid ? r_inst_mem[r_head_ptr] : '0;
  assign bus.pc_o             = w_inst_valid ? r_pc_mem[r_head_ptr]   : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_pc    <= RESET_PC;
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_head_ptr    <= '0;
      r_pend_cnt    <= '0;
      r_fill_cnt    <= '0;
      r_discard_cnt <= '0;
    end else if (bus.redirect_i) begin
      // Every in-flight request becomes a discard; a response this cycle retires one of them.
      r_fetch_pc    <= bus.redirect_pc_i & ~XLEN'(3);
      r_alloc_ptr   <= '0;
      r_fill_ptr    <= '0;
      r_head_ptr    <= '0;
      r_pend_cnt    <= '0;
      r_fill_cnt    <= '0;
      r_discard_cnt <= r_discard_cnt + r_pend_cnt - CW'(bus.imem_rsp_valid_i);
    end else begin
      if (w_accept) begin
        r_fetch_pc  <= r_fetch_pc + XLEN'(4);
        r_alloc_ptr <= r_alloc_ptr + PW'(1);
      end
      if (w_fill) begin
        r_fill_ptr <= r_fill_ptr + PW'(1);
      end
      if (w_pop) begin
        r_head_ptr <= r_head_ptr + PW'(1);
      end
      if (w_drop) begin
        r_discard_cnt <= r_discard_cnt - CW'(1);
      end
      r_pend_cnt <= r_pend_cnt + CW'(w_accept) - CW'(w_fill);
      r_fill_cnt <= r_fill_cnt + CW'(w_fill) - CW'(w_pop);
    end
  end

  // Payload storage needs no reset: outputs are masked by the filled count.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_pc_mem[r_alloc_ptr] <= r_fetch_pc;
    end
    if (w_fill) begin
      r_inst_mem[r_fill_ptr] <= bus.imem_rsp_inst_i;
    end
  end

  a_rsp_expected : assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.imem_rsp_valid_i |-> ((r_pend_cnt != '0) || (r_discard_cnt != '0)));
endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_queue
// Brief    : Self-checking bench: directed vector table plus model-checked random traffic.
// Revision : 1.0
// ============================================================================
module tb_ifu_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  ifu_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  ifu_fetch_queue #(
    .XLEN    (XLEN),
    .ILEN    (ILEN),
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] rsp_pc;
    logic        ir;
    logic        erv;
    logic [31:0] eaddr;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  // Reference model: memory in flight, current stream epoch, expected PCs on both sides.
  mreq_t       mq[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          epoch    = 0;
  int          buffered = 0;
  logic [31:0] exp_req_pc = RESET_PC;
  logic [31:0] exp_dec_pc = RESET_PC;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_idle();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_inst_i  = '0;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.inst_ready_i     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive_idle();
    #1;
    check("rst req_valid", 32'(bus.imem_req_valid_o), 32'd0);
    check("rst inst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst inst", bus.inst_o, 32'd0);
    check("rst pc", bus.pc_o, 32'd0);
    mq.delete();
    buffered   = 0;
    epoch      = 0;
    last_due   = cyc;
    exp_req_pc = RESET_PC;
    exp_dec_pc = RESET_PC;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One clock of model-checked traffic; the memory answers in order after lat cycles.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc,
                      input logic ir, input int lat);
    logic  rsp;
    logic  exp_rv;
    logic  exp_iv;
    mreq_t r;
    int    due;
    @(negedge clk_i);
    rsp = (mq.size() > 0) && (mq[0].due == cyc);
    bus.imem_req_ready_i = rdy;
    bus.redirect_i       = redir;
    bus.redirect_pc_i    = rpc;
    bus.inst_ready_i     = ir;
    bus.imem_rsp_valid_i = rsp;
    bus.imem_rsp_inst_i  = rsp ? inst_of(mq[0].addr) : 32'd0;
    #1;
    exp_rv = !redir && ((mq.size() + buffered) < DEPTH);
    exp_iv = (buffered > 0);
    check("req_valid", 32'(bus.imem_req_valid_o), 32'(exp_rv));
    if (exp_rv) check("req_addr", bus.imem_req_addr_o, exp_req_pc);
    check("inst_valid", 32'(bus.inst_valid_o), 32'(exp_iv));
    if (exp_iv) begin
      check("dec_pc", bus.pc_o, exp_dec_pc);
      check("dec_inst", bus.inst_o, inst_of(exp_dec_pc));
    end
    if (exp_iv && ir) begin
      exp_dec_pc += 32'd4;
      buffered--;
    end
    if (rsp) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !redir) buffered++;
    end
    if (redir) begin
      epoch++;
      buffered   = 0;
      exp_req_pc = rpc & ~32'd3;
      exp_dec_pc = rpc & ~32'd3;
    end
    if (exp_rv && rdy) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{addr: exp_req_pc, due: due, epoch: epoch});
      last_due = due;
      exp_req_pc += 32'd4;
    end
    cyc++;
  endtask

  vec_t tbl[10];

  initial begin
    // Decoder stalled, latency 1: fill to DEPTH, then single pops reopen one slot each.
    tbl[0] = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
    tbl[3] = '{1'b1, 1'b1, 32'h8000_0008, 1'b0, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0000};
    tbl[4] = '{1'b1, 1'b1, 32'h8000_000C, 1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0000};
    tbl[5] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0000};
    tbl[6] = '{1'b1, 1'b0, 32'h0,          1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0004};
    tbl[7] = '{1'b1, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'h0,          1'b1, 32'h8000_0004};
    tbl[8] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b0, 32'h0,          1'b1, 32'h8000_0004};
    tbl[9] = '{1'b1, 1'b0, 32'h0,          1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0008};

    drive_idle();
    repeat (2) @(posedge clk_i);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      bus.imem_req_ready_i = tbl[i].rdy;
      bus.imem_rsp_valid_i = tbl[i].rsp;
      bus.imem_rsp_inst_i  = tbl[i].rsp ? inst_of(tbl[i].rsp_pc) : 32'd0;
      bus.redirect_i       = 1'b0;
      bus.inst_ready_i     = tbl[i].ir;
      #1;
      check($sformatf("tbl%0d req_valid", i), 32'(bus.imem_req_valid_o), 32'(tbl[i].erv));
      if (tbl[i].erv) check($sformatf("tbl%0d req_addr", i), bus.imem_req_addr_o, tbl[i].eaddr);
      check($sformatf("tbl%0d inst_valid", i), 32'(bus.inst_valid_o), 32'(tbl[i].eiv));
      if (tbl[i].eiv) begin
        check($sformatf("tbl%0d pc", i), bus.pc_o, tbl[i].epc);
        check($sformatf("tbl%0d inst", i), bus.inst_o, inst_of(tbl[i].epc));
      end
    end

    // Queue is non-empty here, so this also proves reset clears state asynchronously.
    do_reset();
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1, 1);

    // Redirect to an unaligned target with three requests still in flight.
    do_reset();
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 5);
    step(1'b1, 1'b1, 32'h8000_0103, 1'b0, 5);
    repeat (16) step(1'b1, 1'b0, 32'h0, 1'b1, 2);

    // Redirects in consecutive cycles, each coinciding with an old-stream response.
    do_reset();
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1, 2);
    step(1'b1, 1'b1, 32'h8000_0200, 1'b1, 2);
    step(1'b1, 1'b1, 32'h8000_0300, 1'b1, 2);
    repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1, 2);

    // Fetch PC wraps past the top of the address space, then reset mid-burst.
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1);
    do_reset();
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1, 1);

    // Random backpressure, latency and sparse redirects.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0), $urandom,
           ($urandom_range(0, 2) != 0), int'($urandom_range(1, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
